mtr_cmd_slew: RTL and testbench

Parametrised motor-command output stage for the Segway digital core. It replaces the plain output registering of speed/direction with per-channel slew-rate limiting and reverse-through-zero sequencing. It adds a rider-off ramp-down, a hard power-down kill and a filtered, hysteretic battery-low flag. It sits between balance control and the motor drivers and piezo driver.

---
 rtl/mtr_cmd_slew.sv | 155 +++++++++++++++
 tb/tb_mtr_cmd_slew.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mtr_cmd_slew.sv
// Motor-command output stage: per-channel slew limiting with reverse-through-zero
// sequencing, rider-off ramp-down, power-down kill and a filtered, hysteretic
// battery-low flag.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_vld/cmd_spd/cmd_rev  command strobe, per-channel magnitudes and directions
//   pwr_up                   0 = immediate kill of all outputs
//   rider_off                1 = ramp every channel to zero
//   batt/batt_vld            battery sample and its strobe
//   spd/rev/upd              registered outputs and one-cycle update pulse
//   ramping                  combinational: output differs from latched target
//   batt_low                 filtered battery-low flag
module mtr_cmd_slew #(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned SPD_W        = 11,
   parameter int unsigned SLEW         = 16,
   parameter int unsigned BATT_W       = 12,
   parameter int unsigned BATT_LOW_THR = 12'h800,
   parameter int unsigned BATT_HYST    = 12'h040,
   parameter int unsigned BATT_FILT    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_vld,
   input  logic [NUM_CH*SPD_W-1:0]   cmd_spd,
   input  logic [NUM_CH-1:0]         cmd_rev,
   input  logic                      pwr_up,
   input  logic                      rider_off,
   input  logic [BATT_W-1:0]         batt,
   input  logic                      batt_vld,
   output logic [NUM_CH*SPD_W-1:0]   spd,
   output logic [NUM_CH-1:0]         rev,
   output logic                      upd,
   output logic [NUM_CH-1:0]         ramping,
   output logic                      batt_low
);

   localparam int unsigned CNT_W = 4;
   localparam logic [SPD_W:0]  SLEW_X   = (SPD_W+1)'(SLEW);
   localparam logic [BATT_W:0] LOW_THR  = (BATT_W+1)'(BATT_LOW_THR);
   localparam logic [BATT_W:0] HI_THR   = (BATT_W+1)'(BATT_LOW_THR) + (BATT_W+1)'(BATT_HYST);
   localparam logic [CNT_W-1:0] FILT_N  = CNT_W'(BATT_FILT);

   logic [NUM_CH*SPD_W-1:0] spd_q, spd_nxt, tgt_mag_q, tgt_mag_nxt;
   logic [NUM_CH-1:0]       rev_q, rev_nxt, tgt_dir_q, tgt_dir_nxt;
   logic                    upd_q;
   logic [CNT_W-1:0]        low_cnt_q, hi_cnt_q, low_cnt_nxt, hi_cnt_nxt;
   logic                    batt_low_q;
   logic [SPD_W:0]          cur, tmag, diff, res;
   logic                    tdir;
   logic [BATT_W:0]         batt_x;

   // Per-channel slew step toward the effective target (all math SPD_W+1 wide)
   always_comb begin
      spd_nxt     = spd_q;
      rev_nxt     = rev_q;
      tgt_mag_nxt = tgt_mag_q;
      tgt_dir_nxt = tgt_dir_q;
      cur         = '0;
      tmag        = '0;
      diff        = '0;
      res         = '0;
      tdir        = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cur  = {1'b0, spd_q[i*SPD_W +: SPD_W]};
         tmag = rider_off ? '0 : {1'b0, cmd_spd[i*SPD_W +: SPD_W]};
         tdir = rider_off ? rev_q[i] : cmd_rev[i];
         diff = '0;
         tgt_mag_nxt[i*SPD_W +: SPD_W] = tmag[SPD_W-1:0];
         tgt_dir_nxt[i]                = tdir;
         if (cur == '0) begin
            // Stopped: adopt the new direction and take the first step
            rev_nxt[i] = tdir;
            res        = (tmag < SLEW_X) ? tmag : SLEW_X;
         end else if (tdir == rev_q[i]) begin
            if (tmag >= cur) begin
               diff = tmag - cur;
               res  = (diff <= SLEW_X) ? tmag : cur + SLEW_X;
            end else begin
               diff = cur - tmag;
               res  = (diff <= SLEW_X) ? tmag : cur - SLEW_X;
            end
         end else begin
            // Direction change: decelerate to zero first, direction held
            res = (cur > SLEW_X) ? cur - SLEW_X : '0;
         end
         spd_nxt[i*SPD_W +: SPD_W] = res[SPD_W-1:0];
      end
   end

   // Output and target registers; kill overrides any update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spd_q     <= '0;
         rev_q     <= '0;
         upd_q     <= 1'b0;
         tgt_mag_q <= '0;
         tgt_dir_q <= '0;
      end else if (!pwr_up) begin
         spd_q     <= '0;
         rev_q     <= '0;
         upd_q     <= 1'b0;
         tgt_mag_q <= '0;
         tgt_dir_q <= '0;
      end else if (cmd_vld) begin
         spd_q     <= spd_nxt;
         rev_q     <= rev_nxt;
         upd_q     <= 1'b1;
         tgt_mag_q <= tgt_mag_nxt;
         tgt_dir_q <= tgt_dir_nxt;
      end else begin
         upd_q     <= 1'b0;
      end
   end

   // Battery filter counters, saturating at the filter length
   always_comb begin
      batt_x      = {1'b0, batt};
      low_cnt_nxt = '0;
      hi_cnt_nxt  = '0;
      if (batt_x < LOW_THR)
         low_cnt_nxt = (low_cnt_q == FILT_N) ? low_cnt_q : low_cnt_q + CNT_W'(1);
      if (batt_x >= HI_THR)
         hi_cnt_nxt = (hi_cnt_q == FILT_N) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         low_cnt_q  <= '0;
         hi_cnt_q   <= '0;
         batt_low_q <= 1'b0;
      end else if (batt_vld) begin
         low_cnt_q <= low_cnt_nxt;
         hi_cnt_q  <= hi_cnt_nxt;
         if (low_cnt_nxt == FILT_N)
            batt_low_q <= 1'b1;
         else if (hi_cnt_nxt == FILT_N)
            batt_low_q <= 1'b0;
      end
   end

   // Channel still moving toward its last latched target
   always_comb begin
      ramping = '0;
      for (int i = 0; i < NUM_CH; i++)
         ramping[i] = (spd_q[i*SPD_W +: SPD_W] != tgt_mag_q[i*SPD_W +: SPD_W]) ||
                      (rev_q[i] != tgt_dir_q[i]);
   end

   assign spd      = spd_q;
   assign rev      = rev_q;
   assign upd      = upd_q;
   assign batt_low = batt_low_q;

endmodule

// File: tb/tb_mtr_cmd_slew.sv
// Directed bench for mtr_cmd_slew with default parameters.
module tb_mtr_cmd_slew;

   logic        clk, rst, cmd_vld, pwr_up, rider_off, batt_vld;
   logic [21:0] cmd_spd;
   logic [1:0]  cmd_rev;
   logic [11:0] batt;
   logic [21:0] spd;
   logic [1:0]  rev, ramping;
   logic        upd, batt_low;
   logic [10:0] spd0, spd1;

   int n_chk = 0;
   int n_err = 0;

   assign spd0 = spd[10:0];
   assign spd1 = spd[21:11];

   mtr_cmd_slew dut (
      .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_spd(cmd_spd), .cmd_rev(cmd_rev),
      .pwr_up(pwr_up), .rider_off(rider_off), .batt(batt), .batt_vld(batt_vld),
      .spd(spd), .rev(rev), .upd(upd), .ramping(ramping), .batt_low(batt_low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One command strobe; returns on the negedge after the update edge
   task automatic send(input logic [10:0] s0, input logic [10:0] s1,
                       input logic r0, input logic r1);
      @(negedge clk);
      cmd_spd = {s1, s0};
      cmd_rev = {r1, r0};
      cmd_vld = 1'b1;
      @(negedge clk);
      cmd_vld = 1'b0;
   endtask

   task automatic bsample(input logic [11:0] v);
      @(negedge clk);
      batt     = v;
      batt_vld = 1'b1;
      @(negedge clk);
      batt_vld = 1'b0;
   endtask

   int exp_rtz_spd[5] = '{24, 8, 0, 16, 20};
   int exp_rtz_rev[5] = '{0, 0, 0, 1, 1};
   logic [11:0] bv;
   int e;

   initial begin
      rst = 1'b1; cmd_vld = 1'b0; pwr_up = 1'b1; rider_off = 1'b0;
      batt_vld = 1'b0; batt = 12'hFFF; cmd_spd = '0; cmd_rev = '0;
      repeat (2) @(negedge clk);
      chk("rst_spd", 32'(spd), 32'd0);
      chk("rst_rev", 32'(rev), 32'd0);
      chk("rst_upd", 32'(upd), 32'd0);
      chk("rst_ramping", 32'(ramping), 32'd0);
      chk("rst_batt_low", 32'(batt_low), 32'd0);
      rst = 1'b0;

      // Ramp up to 40 forward
      for (int k = 0; k < 3; k++) begin
         send(11'd40, 11'd0, 1'b0, 1'b0);
         chk($sformatf("ramp_spd0_%0d", k), 32'(spd0), (k == 0) ? 32'd16 : (k == 1) ? 32'd32 : 32'd40);
         chk($sformatf("ramp_upd_%0d", k), 32'(upd), 32'd1);
         chk($sformatf("ramp_ramping0_%0d", k), 32'(ramping[0]), (k < 2) ? 32'd1 : 32'd0);
         chk($sformatf("ramp_ch1_%0d", k), 32'(spd1), 32'd0);
      end
      @(negedge clk);
      chk("upd_one_cycle", 32'(upd), 32'd0);

      // Reverse through zero: 40 fwd -> 20 rev
      for (int k = 0; k < 5; k++) begin
         send(11'd20, 11'd0, 1'b1, 1'b0);
         chk($sformatf("rtz_spd0_%0d", k), 32'(spd0), 32'(exp_rtz_spd[k]));
         chk($sformatf("rtz_rev0_%0d", k), 32'(rev[0]), 32'(exp_rtz_rev[k]));
      end

      // Kill mid-ramp, coincident with a strobe
      send(11'd200, 11'd0, 1'b1, 1'b0);
      chk("pre_kill_spd0", 32'(spd0), 32'd36);
      @(negedge clk);
      pwr_up  = 1'b0;
      cmd_vld = 1'b1;
      @(negedge clk);
      cmd_vld = 1'b0;
      chk("kill_spd", 32'(spd), 32'd0);
      chk("kill_rev", 32'(rev), 32'd0);
      chk("kill_upd", 32'(upd), 32'd0);
      chk("kill_ramping", 32'(ramping), 32'd0);
      pwr_up = 1'b1;

      // Bring both channels to 100, ch1 reverse
      repeat (7) send(11'd100, 11'd100, 1'b0, 1'b1);
      chk("pre_ro_spd0", 32'(spd0), 32'd100);
      chk("pre_ro_spd1", 32'(spd1), 32'd100);
      chk("pre_ro_rev", 32'(rev), 32'd2);

      // Rider off: command contents ignored, ramp to zero, directions held
      rider_off = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send(11'h55, 11'h55, 1'b1, 1'b0);
         e = (100 > 16 * (k + 1)) ? 100 - 16 * (k + 1) : 0;
         chk($sformatf("ro_spd0_%0d", k), 32'(spd0), 32'(e));
         chk($sformatf("ro_spd1_%0d", k), 32'(spd1), 32'(e));
         chk($sformatf("ro_rev_%0d", k), 32'(rev), 32'd2);
      end
      chk("ro_ramping", 32'(ramping), 32'd0);
      rider_off = 1'b0;

      // Saturation near full scale
      repeat (128) send(11'h7F8, 11'd0, 1'b0, 1'b0);
      chk("sat_pre", 32'(spd0), 32'h7F8);
      send(11'h7FF, 11'd0, 1'b0, 1'b0);
      chk("sat_top", 32'(spd0), 32'h7FF);
      chk("sat_ramping", 32'(ramping[0]), 32'd0);
      send(11'h000, 11'd0, 1'b0, 1'b0);
      chk("sat_down", 32'(spd0), 32'h7EF);
      chk("sat_down_ramping", 32'(ramping[0]), 32'd1);

      // Battery filter and hysteresis
      for (int k = 0; k < 3; k++) begin
         bsample(12'h7FF);
         chk($sformatf("bl_a_%0d", k), 32'(batt_low), 32'd0);
      end
      bsample(12'h900);
      chk("bl_break", 32'(batt_low), 32'd0);
      for (int k = 0; k < 4; k++) begin
         bsample(12'h7FF);
         chk($sformatf("bl_set_%0d", k), 32'(batt_low), (k == 3) ? 32'd1 : 32'd0);
      end
      for (int k = 0; k < 10; k++) begin
         bsample(12'h820);
         chk($sformatf("bl_band_%0d", k), 32'(batt_low), 32'd1);
      end
      for (int k = 0; k < 4; k++) begin
         bv = 12'h840;
         bsample(bv);
         chk($sformatf("bl_clr_%0d", k), 32'(batt_low), (k == 3) ? 32'd0 : 32'd1);
      end
      repeat (4) bsample(12'h7FF);
      chk("bl_reset_pre", 32'(batt_low), 32'd1);

      // Asynchronous reset mid-ramp, no clock edge in between
      send(11'h000, 11'd0, 1'b0, 1'b0);
      chk("arst_pre", 32'(spd0), 32'h7DF);
      #2 rst = 1'b1;
      #1;
      chk("arst_spd", 32'(spd), 32'd0);
      chk("arst_rev", 32'(rev), 32'd0);
      chk("arst_upd", 32'(upd), 32'd0);
      chk("arst_ramping", 32'(ramping), 32'd0);
      chk("arst_batt_low", 32'(batt_low), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
